// File: rtl/param_dual_port_sram_pkg.sv
// Shared types, mode constants and the byte-lane merge helper for the
// parametrised dual-port SRAM.
package dp_sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Read-during-write behaviour seen by the opposite port.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Winner of a write-write overlap on the same lane.
  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  // Widest word the merge helper handles; instances cast into and out of it.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_NB     = MAX_DATA_W / 8;

  // Replace the lanes of old_w selected by be with the lanes of new_w.
  function automatic logic [MAX_DATA_W-1:0] merge_lanes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_NB-1:0]     be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/param_dual_port_sram_if.sv
// Bus bundle between two masters and the dual-port SRAM.
interface param_dual_port_sram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) ();
  localparam int NB = DATA_W / 8;

  logic              clear;
  logic              init_done;
  logic              en_a,      en_b;
  logic              we_a,      we_b;
  logic [NB-1:0]     byte_en_a, byte_en_b;
  logic [ADDR_W-1:0] addr_a,    addr_b;
  logic [DATA_W-1:0] din_a,     din_b;
  logic [DATA_W-1:0] dout_a,    dout_b;
  logic              valid_a,   valid_b;
  logic              collision;
  logic [15:0]       coll_cnt;

  modport master (
    output clear, en_a, en_b, we_a, we_b, byte_en_a, byte_en_b,
           addr_a, addr_b, din_a, din_b,
    input  init_done, dout_a, dout_b, valid_a, valid_b, collision, coll_cnt
  );

  modport slave (
    input  clear, en_a, en_b, we_a, we_b, byte_en_a, byte_en_b,
           addr_a, addr_b, din_a, din_b,
    output init_done, dout_a, dout_b, valid_a, valid_b, collision, coll_cnt
  );
endinterface

// File: rtl/param_dual_port_sram_out_stage.sv
// Optional second read-pipeline stage for one port; a wire when OUT_REG=0.
module sram_out_stage #(
  parameter int DATA_W  = 16,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  if (OUT_REG != 0) begin : g_reg
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Delay valid by one cycle; data only moves with a valid beat so it holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_i;
        if (valid_i) data_q <= data_i;
      end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
  end else begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end

endmodule

// File: rtl/param_dual_port_sram.sv
// True dual-port SRAM with byte enables, collision resolution, a saturating
// collision counter and a post-reset / on-request clear sequencer.
module param_dual_port_sram
  import dp_sram_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int RDW_MODE  = RDW_OLD,
  parameter int OUT_REG   = 0,
  parameter int PORT_PRIO = PRIO_A
) (
  input logic                  clk,
  input logic                  rst_n,
  param_dual_port_sram_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

  function automatic word_t merge(input word_t old_w, input word_t new_w,
                                  input logic [NB-1:0] be);
    return DATA_W'(merge_lanes(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w), MAX_NB'(be)));
  endfunction

  word_t             mem [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              accept, wr_a, rd_a, wr_b, rd_b, same_addr;
  logic              coll_d, coll_q;
  logic [15:0]       coll_cnt_d, coll_cnt_q;
  word_t             old_a, old_b, wdata_a, wdata_b, rdata_a, rdata_b;
  word_t             rd_data_a_q, rd_data_b_q;
  logic              rd_valid_a_q, rd_valid_b_q;

  // A clear request in RUN drops any access presented in the same cycle.
  assign accept    = (state_q == RUN) && !bus.clear;
  assign wr_a      = accept && bus.en_a && bus.we_a;
  assign rd_a      = accept && bus.en_a && !bus.we_a;
  assign wr_b      = accept && bus.en_b && bus.we_b;
  assign rd_b      = accept && bus.en_b && !bus.we_b;
  assign same_addr = (bus.addr_a == bus.addr_b);
  assign old_a     = mem[bus.addr_a];
  assign old_b     = mem[bus.addr_b];

  assign coll_d     = accept && bus.en_a && bus.en_b && same_addr && (bus.we_a || bus.we_b);
  assign coll_cnt_d = (coll_d && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

  // Next state: INIT walks the clear pointer across the array, RUN waits for clear.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path infers a latch.
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (bus.clear) begin
          state_d   = INIT;
          clr_ptr_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Write-data merge and read-data selection, including same-address cases.
  always_comb begin
    wdata_a = merge(old_a, bus.din_a, bus.byte_en_a);
    wdata_b = merge(old_b, bus.din_b, bus.byte_en_b);
    if (wr_a && wr_b && same_addr) begin
      // The winner's lanes are applied last so they override on overlap.
      if (PORT_PRIO == PRIO_B)
        wdata_a = merge(merge(old_a, bus.din_a, bus.byte_en_a), bus.din_b, bus.byte_en_b);
      else
        wdata_a = merge(merge(old_a, bus.din_b, bus.byte_en_b), bus.din_a, bus.byte_en_a);
      wdata_b = wdata_a;
    end
    rdata_a = old_a;
    rdata_b = old_b;
    if (RDW_MODE != RDW_OLD) begin
      if (wr_b && same_addr) rdata_a = wdata_b;
      if (wr_a && same_addr) rdata_b = wdata_a;
    end
  end

  // Storage array: zeroed word by word in INIT, otherwise written by both ports.
  // NOTE: the array has no reset; the INIT sequencer clears it so it can map to RAM.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      if (wr_a) mem[bus.addr_a] <= wdata_a;
      if (wr_b) mem[bus.addr_b] <= wdata_b;
    end
  end

  // Control, collision and first read-stage registers.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      clr_ptr_q    <= '0;
      coll_q       <= 1'b0;
      coll_cnt_q   <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      coll_q       <= coll_d;
      coll_cnt_q   <= coll_cnt_d;
      rd_valid_a_q <= rd_a;
      rd_valid_b_q <= rd_b;
      if (rd_a) rd_data_a_q <= rdata_a;
      if (rd_b) rd_data_b_q <= rdata_b;
    end
  end

  sram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_a (
    .clk(clk), .rst_n(rst_n), .valid_i(rd_valid_a_q), .data_i(rd_data_a_q),
    .valid_o(bus.valid_a), .data_o(bus.dout_a)
  );

  sram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_b (
    .clk(clk), .rst_n(rst_n), .valid_i(rd_valid_b_q), .data_i(rd_data_b_q),
    .valid_o(bus.valid_b), .data_o(bus.dout_b)
  );

  assign bus.init_done = (state_q == RUN);
  assign bus.collision = coll_q;
  assign bus.coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_param_dual_port_sram.sv
// Scoreboard bench: two instances (old-data/port-A/no out reg and
// new-data/port-B/out reg) receive identical stimulus; a bench-side model
// predicts read data, latency, collisions, counter and init timing.
module tb_param_dual_port_sram;

  localparam int DEPTH = 32;

  typedef struct {
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [4:0]  addr;
    logic [15:0] din;
  } req_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_dual_port_sram_if #(.DATA_W(16), .ADDR_W(5)) if0 ();
  param_dual_port_sram_if #(.DATA_W(16), .ADDR_W(5)) if1 ();

  param_dual_port_sram #(.DATA_W(16), .ADDR_W(5), .RDW_MODE(0), .OUT_REG(0), .PORT_PRIO(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  param_dual_port_sram #(.DATA_W(16), .ADDR_W(5), .RDW_MODE(1), .OUT_REG(1), .PORT_PRIO(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [15:0] dout_w [4];
  logic        valid_w [4];
  assign dout_w[0] = if0.dout_a;  assign valid_w[0] = if0.valid_a;
  assign dout_w[1] = if0.dout_b;  assign valid_w[1] = if0.valid_b;
  assign dout_w[2] = if1.dout_a;  assign valid_w[2] = if1.valid_a;
  assign dout_w[3] = if1.dout_b;  assign valid_w[3] = if1.valid_b;

  exp_t        sb [4][$];
  logic [15:0] last_dout [4];
  logic [15:0] mdl [2][DEPTH];
  logic        run_m;
  int          init_cnt;
  int          cnt_m;

  string vtag [4] = '{"valid_0a", "valid_0b", "valid_1a", "valid_1b"};
  string dtag [4] = '{"dout_0a", "dout_0b", "dout_1a", "dout_1b"};
  string htag [4] = '{"hold_0a", "hold_0b", "hold_1a", "hold_1b"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic en, input logic we, input logic [1:0] be,
                              input logic [4:0] addr, input logic [15:0] din);
    req_t r;
    r.en = en; r.we = we; r.be = be; r.addr = addr; r.din = din;
    return r;
  endfunction

  function automatic req_t idle_r();
    return mk(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
  endfunction

  function automatic req_t rd_r(input logic [4:0] addr);
    return mk(1'b1, 1'b0, 2'b00, addr, 16'h0);
  endfunction

  function automatic req_t wr_r(input logic [4:0] addr, input logic [15:0] din, input logic [1:0] be);
    return mk(1'b1, 1'b1, be, addr, din);
  endfunction

  function automatic req_t rnd_r();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 16'($urandom));
  endfunction

  task automatic set_inputs(input req_t a, input req_t b, input logic clr);
    if0.clear = clr;            if1.clear = clr;
    if0.en_a = a.en;            if1.en_a = a.en;
    if0.we_a = a.we;            if1.we_a = a.we;
    if0.byte_en_a = a.be;       if1.byte_en_a = a.be;
    if0.addr_a = a.addr;        if1.addr_a = a.addr;
    if0.din_a = a.din;          if1.din_a = a.din;
    if0.en_b = b.en;            if1.en_b = b.en;
    if0.we_b = b.we;            if1.we_b = b.we;
    if0.byte_en_b = b.be;       if1.byte_en_b = b.be;
    if0.addr_b = b.addr;        if1.addr_b = b.addr;
    if0.din_b = b.din;          if1.din_b = b.din;
  endtask

  // One clock of stimulus: update the model, push expected reads, then check
  // the per-cycle outputs just after the edge.
  task automatic step(input req_t a, input req_t b, input logic clr);
    logic acc, wa, ra, wb, rb, same, coll;
    logic [15:0] old_a, old_b, ra_d, rb_d;
    acc  = run_m && !clr;
    wa   = acc && a.en && a.we;
    ra   = acc && a.en && !a.we;
    wb   = acc && b.en && b.we;
    rb   = acc && b.en && !b.we;
    same = (a.addr == b.addr);
    coll = acc && a.en && b.en && same && (a.we || b.we);
    for (int d = 0; d < 2; d++) begin
      old_a = mdl[d][a.addr];
      old_b = mdl[d][b.addr];
      for (int i = 0; i < 2; i++) begin
        if (wa && a.be[i] && !(d == 1 && wb && same && b.be[i]))
          mdl[d][a.addr][8*i +: 8] = a.din[8*i +: 8];
        if (wb && b.be[i] && !(d == 0 && wa && same && a.be[i]))
          mdl[d][b.addr][8*i +: 8] = b.din[8*i +: 8];
      end
      ra_d = (d == 1 && wb && same) ? mdl[d][a.addr] : old_a;
      rb_d = (d == 1 && wa && same) ? mdl[d][b.addr] : old_b;
      if (ra) sb[2*d].push_back('{cyc + 1 + d, ra_d});
      if (rb) sb[2*d+1].push_back('{cyc + 1 + d, rb_d});
    end
    set_inputs(a, b, clr);
    @(posedge clk);
    #1;
    if (coll && cnt_m < 65535) cnt_m++;
    if (!run_m) begin
      init_cnt++;
      if (init_cnt == DEPTH) run_m = 1'b1;
    end else if (clr) begin
      run_m    = 1'b0;
      init_cnt = 0;
      for (int d = 0; d < 2; d++) for (int k = 0; k < DEPTH; k++) mdl[d][k] = 16'h0;
    end
    check("init_done0", 32'(if0.init_done), 32'(run_m));
    check("init_done1", 32'(if1.init_done), 32'(run_m));
    check("collision0", 32'(if0.collision), 32'(coll));
    check("collision1", 32'(if1.collision), 32'(coll));
    check("coll_cnt0",  32'(if0.coll_cnt),  32'(cnt_m));
    check("coll_cnt1",  32'(if1.coll_cnt),  32'(cnt_m));
  endtask

  task automatic idle(input int n);
    repeat (n) step(idle_r(), idle_r(), 1'b0);
  endtask

  // Assert reset between edges, check outputs react at once, reset the model.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_dout",  32'(dout_w[i]),  32'd0);
      check("rst_valid", 32'(valid_w[i]), 32'd0);
    end
    check("rst_init_done0", 32'(if0.init_done), 32'd0);
    check("rst_init_done1", 32'(if1.init_done), 32'd0);
    check("rst_collision0", 32'(if0.collision), 32'd0);
    check("rst_collision1", 32'(if1.collision), 32'd0);
    check("rst_coll_cnt0",  32'(if0.coll_cnt),  32'd0);
    check("rst_coll_cnt1",  32'(if1.coll_cnt),  32'd0);
    for (int i = 0; i < 4; i++) begin
      sb[i].delete();
      last_dout[i] = 16'h0;
    end
    run_m    = 1'b0;
    init_cnt = 0;
    cnt_m    = 0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < DEPTH; k++) mdl[d][k] = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Read monitor: a due entry must appear with valid and matching data;
  // otherwise valid must be low and dout must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
          exp_t e;
          e = sb[i].pop_front();
          check(vtag[i], 32'(valid_w[i]), 32'd1);
          check(dtag[i], 32'(dout_w[i]), 32'(e.data));
        end else begin
          check(vtag[i], 32'(valid_w[i]), 32'd0);
          check(htag[i], 32'(dout_w[i]), 32'(last_dout[i]));
        end
        last_dout[i] = dout_w[i];
      end
    end
  end

  initial begin
    set_inputs(idle_r(), idle_r(), 1'b0);
    do_reset();
    idle(DEPTH);

    // Freshly initialised words read as zero.
    step(rd_r(5'd0), rd_r(5'd17), 1'b0);
    step(rd_r(5'd31), idle_r(), 1'b0);
    idle(2);

    // Byte-lane writes on both ports.
    step(wr_r(5'd2, 16'hDEAD, 2'b11), wr_r(5'd3, 16'hBEEF, 2'b10), 1'b0);
    step(rd_r(5'd2), rd_r(5'd3), 1'b0);

    // Write-write collision, then both ports reading the same word.
    step(wr_r(5'd5, 16'h1234, 2'b11), wr_r(5'd5, 16'hABCD, 2'b01), 1'b0);
    step(rd_r(5'd5), rd_r(5'd5), 1'b0);

    // Read-during-write on the opposite port.
    step(wr_r(5'd7, 16'h1111, 2'b11), idle_r(), 1'b0);
    step(wr_r(5'd7, 16'h2222, 2'b11), rd_r(5'd7), 1'b0);
    step(idle_r(), rd_r(5'd7), 1'b0);

    // Same-port read-after-write.
    step(wr_r(5'd10, 16'h5A5A, 2'b01), idle_r(), 1'b0);
    step(rd_r(5'd10), idle_r(), 1'b0);

    // Back-to-back reads every cycle.
    for (int i = 0; i < 8; i++)
      step(wr_r(5'(16 + i), 16'(16'h1100 * i + 3), 2'b11),
           wr_r(5'(24 + i), 16'(16'h0F0F ^ (i * 16'h0101)), 2'b11), 1'b0);
    for (int i = 0; i < 8; i++) step(rd_r(5'(16 + i)), rd_r(5'(31 - i)), 1'b0);
    idle(3);

    // Random traffic over a few addresses to provoke conflicts.
    repeat (300) step(rnd_r(), rnd_r(), 1'b0);
    idle(3);

    // Clear with accesses in the same cycle, then everything reads zero.
    step(wr_r(5'd1, 16'hFFFF, 2'b11), rd_r(5'd2), 1'b1);
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(rd_r(5'(i)), rd_r(5'(31 - i)), 1'b0);
    idle(3);

    // Reset while running with non-zero dout, then again in the middle of INIT.
    step(wr_r(5'd4, 16'hC3C3, 2'b11), idle_r(), 1'b0);
    step(rd_r(5'd4), rd_r(5'd4), 1'b0);
    idle(2);
    do_reset();
    idle(10);
    do_reset();
    idle(DEPTH);
    step(rd_r(5'd4), rd_r(5'd2), 1'b0);
    idle(2);

    // Collision counter saturation.
    repeat (65540) step(wr_r(5'd9, 16'h00AA, 2'b01), wr_r(5'd9, 16'hBB00, 2'b10), 1'b0);
    idle(3);

    for (int i = 0; i < 4; i++) check("sb_empty", 32'(sb[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_dual_port_sram.md
# param_dual_port_sram

Parametrised true dual-port synchronous SRAM with per-byte write enables. It is the successor to the fixed 32×16 `dual_port_sram`. Over that block it adds:
- configurable width and depth,
- a selectable read-during-write mode,
- an optional output register stage,
- deterministic same-address collision resolution with a saturating collision counter,
- a hardware memory-clear sequencer that runs after reset or on request.

It sits between two independent masters sharing one storage array on a single clock.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- NB, DATA_W/8, number of byte lanes (derived, not overridable).
- RDW_MODE, 0, read-during-write on the opposite port: 0 = old data, 1 = new data.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- PORT_PRIO, 0, write-write winner on overlapping lanes: 0 = port A, 1 = port B.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  one-cycle request to re-run the memory clear.
- init_done  out  1  high when the array is usable.
- en_a / en_b  in  1  port enable.
- we_a / we_b  in  1  1 = write, 0 = read (when enabled).
- byte_en_a / byte_en_b  in  NB  lane write enables (bit i covers bits 8i+7:8i).
- addr_a / addr_b  in  ADDR_W  word address.
- din_a / din_b  in  DATA_W  write data.
- dout_a / dout_b  out  DATA_W  read data.
- valid_a / valid_b  out  1  dout carries data for a read issued at the read latency.
- collision  out  1  one-cycle pulse: same-address conflict.
- coll_cnt  out  16  saturating count of collision pulses.

## Operation
- FSM states: INIT, RUN.
  - Reset → INIT. INIT writes zero to address 0..DEPTH-1, one word per cycle, then → RUN.
  - `clear` high in RUN → INIT. Port accesses in that same cycle are dropped.
- In INIT:
  - All port accesses are ignored.
  - `valid_a`/`valid_b` stay 0 and collision detection is off.
  - `init_done` = 0.
- Write (en & we): only lanes with a byte_en bit set are updated. `we` with byte_en = 0 is a no-op. Writes produce no `valid`.
- Read (en & !we): the addressed word is returned and the matching `valid` is asserted at the read latency. `dout` holds its last value when `valid` = 0.
- Same-address, both ports writing:
  - Lanes enabled on only one port take that port's data.
  - Overlapping lanes take the data of the PORT_PRIO winner.
  - Collision is flagged.
- Same-address, one port reading and the other writing:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: written lanes new, other lanes old.
  - Collision is flagged.
- Same-address, both ports reading: both return the same word; no collision.
- Same-port read-after-write to the same address in the following cycle returns the new data.
- `coll_cnt` increments by one per collision pulse and saturates at 16'hFFFF. It is cleared only by reset, not by `clear`.
- Async reset mid-INIT or mid-RUN:
  - All registers go immediately to their reset values.
  - INIT restarts at address 0.
  - Array contents are undefined until INIT completes.

## Timing
- Reset values: dout_a = dout_b = 0, valid_a = valid_b = 0, collision = 0, coll_cnt = 0, init_done = 0, state = INIT, clear pointer = 0.
- INIT sequence:
  - The first rising edge with rst_n high clears address 0.
  - Edge DEPTH clears address DEPTH-1 and sets init_done. The first accepted access occurs on edge DEPTH+1.
- Read latency:
  - OUT_REG=0: dout/valid are updated at the edge that samples the request (1 cycle).
  - OUT_REG=1: +1 cycle.
- collision: asserted for exactly the cycle after the conflicting requests are sampled, independent of OUT_REG. coll_cnt is updated at the same edge.
- clear: sampled at a rising edge. init_done falls at that same edge. The INIT duration is again DEPTH cycles.

## Structure
- Package `dp_sram_pkg` holds:
  - the state enum (INIT, RUN),
  - RDW_OLD/RDW_NEW constants,
  - PRIO_A/PRIO_B constants,
  - a lane-merge function (old word, new word, byte enable → merged word).
- Sub-module `sram_out_stage`, instantiated once per port: the optional output register plus valid pipeline. With OUT_REG=0 it is a pass-through.
- The top level contains the array, the FSM and clear pointer, the collision detect/merge logic, and the counter.

## Test plan
- Reset release with DEPTH=32 → init_done rises on edge 32. Reads of address 0, 17 and 31 all return 16'h0000 with valid after 1 cycle.
- Write A addr 2 = DEAD with byte_en 11, and write B addr 3 = BEEF with byte_en 10 → reads return A: DEAD, B: BE00.
- Both ports write addr 5 in one cycle: A = 1234 with be 11, B = ABCD with be 01 → PORT_PRIO=0 gives 1234 and PORT_PRIO=1 gives 12CD; collision pulses once and coll_cnt = 1.
- Addr 7 preloaded with 1111; A writes 2222 while B reads addr 7 → RDW_MODE=0 returns 1111, RDW_MODE=1 returns 2222; collision is flagged.
- OUT_REG=1: a read issued on cycle n → valid and data appear on cycle n+2. Back-to-back reads on every cycle → one valid per cycle, in request order.
- Additional directed checks:
  - `clear` pulse after writes → init_done low for 32 cycles, then all locations read 0.
  - rst_n asserted mid-INIT → outputs return to reset values immediately, and INIT restarts from address 0.
  - Forced 65536 collisions → coll_cnt holds at FFFF.
